fp_stream_alu: RTL and testbench

FP_STREAM_ALU -- requirements
Module: fp_stream_alu

---
 rtl/fp_alu_pkg.sv | 32 +++
 rtl/fp_addsub.sv | 103 ++++++++++
 rtl/fp_stream_alu.sv | 165 ++++++++++++++++
 tb/tb_fp_stream_alu.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_alu_pkg.sv
// Shared encodings for the streaming FP32 add/subtract unit: FSM states,
// opcodes, the word width and a leading-zero counter used by the adder.
package fp_alu_pkg;

    localparam int FP32_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_OUTPUT = 3'd4
    } state_e;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_SUB     = 2'b01;
    localparam logic [1:0] OP_RSUB    = 2'b10;
    localparam logic [1:0] OP_ABSDIFF = 2'b11;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic found;
        found = 1'b0;
        lzc27 = 5'd0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                found = 1'b1;
                lzc27 = 5'(26 - i);
            end
        end
    endfunction

endpackage

// File: rtl/fp_addsub.sv
// Combinational IEEE-754 single-precision add/subtract, round-to-nearest-even.
// Subnormal inputs and results are flushed to zero.
module fp_addsub
    import fp_alu_pkg::*;
(
    input  logic [FP32_W-1:0] a,
    input  logic [FP32_W-1:0] b,
    input  logic              sub,
    output logic [FP32_W-1:0] result
);

    logic [31:0] bx;
    logic [31:0] l;
    logic [31:0] s;
    logic        swap;
    logic        eff_sub;
    logic [7:0]  el;
    logic [7:0]  es;
    logic [7:0]  d_exp;
    logic [4:0]  sh;
    logic [23:0] ml;
    logic [23:0] ms;
    logic [49:0] tmp;
    logic [26:0] sm;
    logic [27:0] lx;
    logic [27:0] sx;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [26:0] norm;
    logic        round_up;
    logic [24:0] mant;
    logic signed [9:0] exp_n;
    logic signed [9:0] exp_r;
    logic [22:0] frac;
    logic        a_nan;
    logic        b_nan;
    logic        a_inf;
    logic        b_inf;

    assign bx   = {b[31] ^ sub, b[30:0]};
    assign swap = bx[30:0] > a[30:0];
    assign l    = swap ? bx : a;
    assign s    = swap ? a : bx;

    assign eff_sub = l[31] ^ s[31];
    assign el      = l[30:23];
    assign es      = s[30:23];
    assign ml      = (el != 8'd0) ? {1'b1, l[22:0]} : 24'd0;
    assign ms      = (es != 8'd0) ? {1'b1, s[22:0]} : 24'd0;
    assign d_exp   = el - es;
    assign sh      = (d_exp > 8'd31) ? 5'd31 : d_exp[4:0];

    // Align the smaller operand; everything shifted past the round bit folds into sticky.
    assign tmp = {ms, 26'd0} >> sh;
    assign sm  = {tmp[49:24], tmp[23] | (|tmp[22:0])};
    assign lx  = {1'b0, ml, 3'b000};
    assign sx  = {1'b0, sm};
    assign sum = eff_sub ? (lx - sx) : (lx + sx);

    assign a_nan = (&a[30:23]) & (|a[22:0]);
    assign b_nan = (&bx[30:23]) & (|bx[22:0]);
    assign a_inf = (&a[30:23]) & ~(|a[22:0]);
    assign b_inf = (&bx[30:23]) & ~(|bx[22:0]);

    always_comb begin
        lz = lzc27(sum[26:0]);
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = $signed({2'b00, el}) + 10'sd1;
        end else begin
            norm  = sum[26:0] << lz;
            exp_n = $signed({2'b00, el}) - $signed({5'd0, lz});
        end
        round_up = norm[2] & (norm[3] | norm[1] | norm[0]);
        mant     = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (mant[24]) begin
            exp_r = exp_n + 10'sd1;
            frac  = mant[23:1];
        end else begin
            exp_r = exp_n;
            frac  = mant[22:0];
        end
    end

    always_comb begin
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] ^ bx[31]))) begin
            result = 32'h7FC0_0000;
        end else if (a_inf) begin
            result = {a[31], 8'hFF, 23'd0};
        end else if (b_inf) begin
            result = {bx[31], 8'hFF, 23'd0};
        end else if (sum == 28'd0) begin
            result = eff_sub ? 32'd0 : {l[31], 31'd0};
        end else if (exp_r >= 10'sd255) begin
            result = {l[31], 8'hFF, 23'd0};
        end else if (exp_r <= 10'sd0) begin
            result = {l[31], 31'd0};
        end else begin
            result = {l[31], exp_r[7:0], frac};
        end
    end

endmodule

// File: rtl/fp_stream_alu.sv
// Streaming FP32 add/sub: operands arrive as BUS_W-wide beats (LS first), the
// result leaves the same way after EXEC_LAT cycles of settle time for the adder.
//
// state     | meaning
// IDLE      | waiting for A beat 0 (captures opcode)
// LOAD_A    | collecting remaining A beats
// LOAD_B    | collecting B beats
// EXEC      | adder settling, result registered on last cycle
// OUTPUT    | presenting result beats
module fp_stream_alu
    import fp_alu_pkg::*;
#(
    parameter int BUS_W    = 8,
    parameter int EXEC_LAT = 1
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BUS_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       opcode,
    input  logic             abort,
    output logic [BUS_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [2:0]       state_out
);

    localparam int               BEATS     = FP32_W / BUS_W;
    localparam int               CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [1:0]       EXEC_INIT = 2'(EXEC_LAT - 1);

    state_e              state_q;
    logic [CNT_W-1:0]    beat_q;
    logic [1:0]          exec_q;
    logic [FP32_W-1:0]   a_q;
    logic [FP32_W-1:0]   b_q;
    logic [FP32_W-1:0]   result_q;
    logic [1:0]          op_q;
    logic                out_valid_q;

    logic [FP32_W-1:0]   add_a;
    logic [FP32_W-1:0]   add_b;
    logic [FP32_W-1:0]   add_res;
    logic [FP32_W-1:0]   res_fixed;
    logic                add_sub;
    logic                in_fire;
    logic                out_fire;
    logic                last_beat;

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid_q & out_ready;
    assign last_beat = (beat_q == LAST_BEAT);

    // Reverse subtract reuses the single adder by swapping its inputs.
    assign add_a     = (op_q == OP_RSUB) ? b_q : a_q;
    assign add_b     = (op_q == OP_RSUB) ? a_q : b_q;
    assign add_sub   = (op_q != OP_ADD);
    assign res_fixed = {(op_q == OP_ABSDIFF) ? 1'b0 : add_res[31], add_res[30:0]};

    fp_addsub u_addsub (
        .a      (add_a),
        .b      (add_b),
        .sub    (add_sub),
        .result (add_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            exec_q      <= 2'd0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            op_q        <= OP_ADD;
            out_valid_q <= 1'b0;
        end else if (abort) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            exec_q      <= 2'd0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            op_q        <= OP_ADD;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_fire) begin
                        a_q[BUS_W-1:0] <= in_data;
                        op_q           <= opcode;
                        beat_q         <= (BEATS == 1) ? '0 : CNT_W'(1);
                        state_q        <= (BEATS == 1) ? ST_LOAD_B : ST_LOAD_A;
                    end
                end
                ST_LOAD_A: begin
                    if (in_fire) begin
                        a_q[int'(beat_q)*BUS_W +: BUS_W] <= in_data;
                        if (last_beat) begin
                            beat_q  <= '0;
                            state_q <= ST_LOAD_B;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (in_fire) begin
                        b_q[int'(beat_q)*BUS_W +: BUS_W] <= in_data;
                        if (last_beat) begin
                            beat_q  <= '0;
                            exec_q  <= EXEC_INIT;
                            state_q <= ST_EXEC;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    if (exec_q == 2'd0) begin
                        result_q    <= res_fixed;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUTPUT;
                    end else begin
                        exec_q <= exec_q - 2'd1;
                    end
                end
                ST_OUTPUT: begin
                    if (out_fire) begin
                        if (last_beat) begin
                            beat_q      <= '0;
                            out_valid_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    beat_q      <= '0;
                    exec_q      <= 2'd0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        out_data = '0;
        if (out_valid_q) begin
            out_data = result_q[int'(beat_q)*BUS_W +: BUS_W];
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign state_out = state_q;

endmodule

// File: tb/tb_fp_stream_alu.sv
// Bench for fp_stream_alu: three instances (8/32/16-bit beats) driven from a vector
// table with a result queue, plus abort and mid-output reset sequences.
module tb_fp_stream_alu;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] in_data_v   [3];
    logic        in_valid_v  [3];
    logic [1:0]  opcode_v    [3];
    logic        abort_v     [3];
    logic        out_ready_v [3];

    logic [7:0]  od0;
    logic [31:0] od1;
    logic [15:0] od2;
    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic        bz0, bz1, bz2;
    logic [2:0]  st0, st1, st2;

    fp_stream_alu #(.BUS_W(8), .EXEC_LAT(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_v[0][7:0]), .in_valid(in_valid_v[0]),
        .in_ready(ir0), .opcode(opcode_v[0]), .abort(abort_v[0]), .out_data(od0),
        .out_valid(ov0), .out_ready(out_ready_v[0]), .busy(bz0), .state_out(st0)
    );

    fp_stream_alu #(.BUS_W(32), .EXEC_LAT(3)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_v[1]), .in_valid(in_valid_v[1]),
        .in_ready(ir1), .opcode(opcode_v[1]), .abort(abort_v[1]), .out_data(od1),
        .out_valid(ov1), .out_ready(out_ready_v[1]), .busy(bz1), .state_out(st1)
    );

    fp_stream_alu #(.BUS_W(16), .EXEC_LAT(2)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_v[2][15:0]), .in_valid(in_valid_v[2]),
        .in_ready(ir2), .opcode(opcode_v[2]), .abort(abort_v[2]), .out_data(od2),
        .out_valid(ov2), .out_ready(out_ready_v[2]), .busy(bz2), .state_out(st2)
    );

    typedef struct {
        int          dut;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        int          gap;
        bit          tog;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [14];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic int bw(input int d);
        return (d == 0) ? 8 : (d == 1) ? 32 : 16;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 2;
    endfunction

    function automatic logic [31:0] f_od(input int d);
        return (d == 0) ? {24'd0, od0} : (d == 1) ? od1 : {16'd0, od2};
    endfunction

    function automatic logic f_ir(input int d);
        return (d == 0) ? ir0 : (d == 1) ? ir1 : ir2;
    endfunction

    function automatic logic f_ov(input int d);
        return (d == 0) ? ov0 : (d == 1) ? ov1 : ov2;
    endfunction

    function automatic logic f_bz(input int d);
        return (d == 0) ? bz0 : (d == 1) ? bz1 : bz2;
    endfunction

    function automatic logic [2:0] f_st(input int d);
        return (d == 0) ? st0 : (d == 1) ? st1 : st2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int d, input logic [31:0] data);
        in_data_v[d]  = data;
        in_valid_v[d] = 1'b1;
        check("in_ready_load", 32'(f_ir(d)), 32'd1);
        tick();
        in_valid_v[d] = 1'b0;
    endtask

    task automatic drive_op(input int d, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] op, input int gap);
        int          w;
        int          beats;
        logic [31:0] mask;
        logic [31:0] word;
        w     = bw(d);
        beats = 32 / w;
        mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        opcode_v[d] = op;
        for (int i = 0; i < 2 * beats; i++) begin
            word = (i < beats) ? a : b;
            send_beat(d, (word >> ((i % beats) * w)) & mask);
            opcode_v[d] = ~op;
            if (i < 2 * beats - 1) repeat (gap) tick();
        end
    endtask

    task automatic collect(input int d, input bit tog);
        int          w;
        int          beats;
        int          lat;
        logic [31:0] word;
        logic [31:0] bv;
        logic [31:0] expv;
        w     = bw(d);
        beats = 32 / w;
        lat   = 0;
        do begin
            tick();
            lat++;
        end while (!f_ov(d) && lat < 20);
        check("latency", 32'(lat), 32'(lat_of(d)));
        word = 32'd0;
        if (f_ov(d)) begin
            for (int i = 0; i < beats; i++) begin
                bv = f_od(d);
                check("out_valid_beat", 32'(f_ov(d)), 32'd1);
                if (tog) begin
                    out_ready_v[d] = 1'b0;
                    tick();
                    check("stall_hold", f_od(d), bv);
                end
                out_ready_v[d] = 1'b1;
                tick();
                out_ready_v[d] = 1'b0;
                word = word | (bv << (i * w));
            end
            check("out_valid_end", 32'(f_ov(d)), 32'd0);
            check("out_data_idle", f_od(d), 32'd0);
            check("busy_end", 32'(f_bz(d)), 32'd0);
        end
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL result: got %h with no expected entry queued", word);
        end else begin
            expv = exp_q.pop_front();
            check("result", word, expv);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{0, 32'h3F80_0000, 32'h4000_0000, 2'b00, 0, 1'b0, 32'h4040_0000};
        vecs[1]  = '{1, 32'h3F80_0000, 32'h4000_0000, 2'b01, 0, 1'b0, 32'hBF80_0000};
        vecs[2]  = '{1, 32'h3F80_0000, 32'h4000_0000, 2'b10, 0, 1'b0, 32'h3F80_0000};
        vecs[3]  = '{1, 32'h3F80_0000, 32'h4000_0000, 2'b11, 0, 1'b0, 32'h3F80_0000};
        vecs[4]  = '{2, 32'h3F80_0000, 32'h4000_0000, 2'b00, 0, 1'b0, 32'h4040_0000};
        vecs[5]  = '{2, 32'h3F80_0000, 32'h4000_0000, 2'b00, 2, 1'b1, 32'h4040_0000};
        vecs[6]  = '{0, 32'h3FC0_0000, 32'h3FC0_0000, 2'b00, 1, 1'b1, 32'h4040_0000};
        vecs[7]  = '{0, 32'h4000_0000, 32'h4000_0000, 2'b01, 0, 1'b0, 32'h0000_0000};
        vecs[8]  = '{1, 32'h3F80_0000, 32'hBF80_0000, 2'b00, 0, 1'b0, 32'h0000_0000};
        vecs[9]  = '{2, 32'h3F80_0000, 32'h3F00_0000, 2'b10, 0, 1'b0, 32'hBF00_0000};
        vecs[10] = '{0, 32'h3F00_0000, 32'h4000_0000, 2'b11, 0, 1'b0, 32'h3FC0_0000};
        vecs[11] = '{1, 32'h3F80_0000, 32'h3380_0000, 2'b00, 0, 1'b0, 32'h3F80_0000};
        vecs[12] = '{2, 32'h3F80_0000, 32'h33C0_0000, 2'b00, 1, 1'b0, 32'h3F80_0001};
        vecs[13] = '{0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 2'b00, 0, 1'b0, 32'h7F80_0000};

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_data_v[d]   = 32'd0;
            in_valid_v[d]  = 1'b0;
            opcode_v[d]    = 2'b00;
            abort_v[d]     = 1'b0;
            out_ready_v[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_out_valid", 32'(f_ov(d)), 32'd0);
            check("rst_out_data", f_od(d), 32'd0);
            check("rst_busy", 32'(f_bz(d)), 32'd0);
            check("rst_state", 32'(f_st(d)), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) check("rst_in_ready", 32'(f_ir(d)), 32'd1);
        tick();

        // Table: each op starts in the cycle right after the previous one finished.
        for (int i = 0; i < 14; i++) begin
            check("in_ready_start", 32'(f_ir(vecs[i].dut)), 32'd1);
            exp_q.push_back(vecs[i].exp);
            drive_op(vecs[i].dut, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].gap);
            collect(vecs[i].dut, vecs[i].tog);
        end

        // Abort on the final B beat of the 16-bit instance, then a clean 1.0 + 1.0.
        opcode_v[2] = 2'b00;
        send_beat(2, 32'h0000_0000);
        send_beat(2, 32'h0000_3F80);
        send_beat(2, 32'h0000_0000);
        in_data_v[2]  = 32'h0000_4000;
        in_valid_v[2] = 1'b1;
        abort_v[2]    = 1'b1;
        tick();
        abort_v[2]    = 1'b0;
        in_valid_v[2] = 1'b0;
        check("abort_state", 32'(st2), 32'd0);
        check("abort_busy", 32'(bz2), 32'd0);
        repeat (4) tick();
        check("abort_no_stale", 32'(ov2), 32'd0);
        exp_q.push_back(32'h4000_0000);
        drive_op(2, 32'h3F80_0000, 32'h3F80_0000, 2'b00, 0);
        collect(2, 1'b0);

        // Reset pulse after two output beats of the 8-bit instance.
        drive_op(0, 32'h3F80_0000, 32'h4000_0000, 2'b00, 0);
        for (int t = 0; t < 20 && !ov0; t++) tick();
        check("pre_reset_valid", 32'(ov0), 32'd1);
        out_ready_v[0] = 1'b1;
        tick();
        tick();
        out_ready_v[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(ov0), 32'd0);
        check("mid_rst_state", 32'(st0), 32'd0);
        check("mid_rst_out_data", {24'd0, od0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(ir0), 32'd1);
        tick();
        exp_q.push_back(32'h4000_0000);
        drive_op(0, 32'h3F80_0000, 32'h3F80_0000, 2'b00, 0);
        collect(0, 1'b0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
